axi_sim_mem_slave: RTL and testbench



---
 rtl/axi_sim_mem_slave_pkg.sv | 25 ++
 rtl/axi_sim_mem_slave_if.sv | 55 +++++
 rtl/axi_sim_mem_slave_lat_ctr.sv | 27 ++
 rtl/axi_sim_mem_slave.sv | 258 +++++++++++++++++++++++++
 tb/tb_axi_sim_mem_slave.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_sim_mem_slave_pkg.sv
// Shared constants and FSM state types for the AXI4 simulation memory slave.
package axi_sim_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_WAIT = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_WAIT = 2'b01,
        R_RESP = 2'b10
    } r_state_e;

endpackage

// File: rtl/axi_sim_mem_slave_if.sv
// AXI4 single-beat bus bundle between a master and the simulation memory slave.
interface axi_sim_mem_slave_if #(
    parameter int IDW = 4,
    parameter int DW  = 32,
    parameter int AW  = 32
);
    logic            awvalid;
    logic            awready;
    logic [IDW-1:0]  awid;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awsize;
    logic [2:0]      awprot;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [IDW-1:0]  bid;
    logic            arvalid;
    logic            arready;
    logic [IDW-1:0]  arid;
    logic [AW-1:0]   araddr;
    logic [2:0]      arsize;
    logic [2:0]      arprot;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [IDW-1:0]  rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;

    modport master (
        output awvalid, awid, awaddr, awsize, awprot, awlen, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arsize, arprot, arlen, arburst, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awid, awaddr, awsize, awprot, awlen, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arsize, arprot, arlen, arburst, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/axi_sim_mem_slave_lat_ctr.sv
// Response-latency countdown: load a value, count to zero, then rest with done high.
module axi_sim_lat_ctr (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       done_o
);

    logic [3:0] cnt_q;

    // Countdown register, saturating at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/axi_sim_mem_slave.sv
// Single-beat AXI4 slave memory with independent read/write channels and fixed response latency.
module axi_sim_mem_slave
    import axi_sim_pkg::*;
#(
    parameter int            IDW       = 4,
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            MEM_WORDS = 1024,
    parameter logic [AW-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int            RD_LAT    = 2,
    parameter int            WR_LAT    = 1
) (
    input  logic                clk,
    input  logic                resetn,
    axi_sim_mem_slave_if.slave  axi
);

    localparam int            SB       = DW / 8;
    localparam int            LG       = $clog2(SB);
    localparam int            IW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0]    MAX_SIZE = 3'(LG);
    localparam logic [AW-1:0] WORDS_A  = AW'(MEM_WORDS);
    localparam logic [3:0]    WR_LAT_V = 4'(WR_LAT);
    localparam logic [3:0]    RD_LAT_V = 4'(RD_LAT);

    function automatic logic in_range(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> LG) < WORDS_A);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] addr);
        return IW'((addr - BASE_ADDR) >> LG);
    endfunction

    logic [DW-1:0] mem_q [MEM_WORDS];

    w_state_e        w_state_q;
    logic            aw_held_q, w_held_q, awready_q, wready_q, bvalid_q;
    logic [IDW-1:0]  aw_id_q, bid_q;
    logic [AW-1:0]   aw_addr_q;
    logic [7:0]      aw_len_q;
    logic [2:0]      aw_size_q;
    logic [DW-1:0]   w_data_q;
    logic [SB-1:0]   w_strb_q;
    logic            w_last_q;
    logic [1:0]      bresp_q, wr_resp_s;
    logic            aw_hs_s, w_hs_s, aw_got_s, w_got_s, wr_load_s, wr_done_s, wr_commit_s;
    logic [IW-1:0]   wr_idx_s;

    r_state_e        r_state_q;
    logic            arready_q, rvalid_q, rlast_q;
    logic [IDW-1:0]  ar_id_q, rid_q;
    logic [AW-1:0]   ar_addr_q;
    logic [7:0]      ar_len_q;
    logic [2:0]      ar_size_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      rresp_q, rd_resp_s;
    logic            ar_hs_s, rd_load_s, rd_done_s;
    logic [IW-1:0]   rd_idx_s;
    logic            unused_s;

    assign aw_hs_s     = axi.awvalid & awready_q;
    assign w_hs_s      = axi.wvalid & wready_q;
    assign aw_got_s    = aw_held_q | aw_hs_s;
    assign w_got_s     = w_held_q | w_hs_s;
    assign wr_load_s   = (w_state_q == W_IDLE) & aw_got_s & w_got_s;
    assign wr_commit_s = (w_state_q == W_WAIT) & wr_done_s;
    assign wr_idx_s    = word_idx(aw_addr_q);
    assign ar_hs_s     = axi.arvalid & arready_q;
    assign rd_load_s   = (r_state_q == R_IDLE) & ar_hs_s;
    assign rd_idx_s    = word_idx(ar_addr_q);
    assign unused_s    = ^{axi.awprot, axi.awburst, axi.arprot, axi.arburst};

    axi_sim_lat_ctr u_wr_lat (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (wr_load_s),
        .load_val_i (WR_LAT_V),
        .done_o     (wr_done_s)
    );

    axi_sim_lat_ctr u_rd_lat (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (rd_load_s),
        .load_val_i (RD_LAT_V),
        .done_o     (rd_done_s)
    );

    // Write response code for the held beat; decode errors win over protocol errors.
    always_comb begin
        if (!in_range(aw_addr_q)) begin
            wr_resp_s = RESP_DECERR;
        end else if ((aw_len_q != 8'd0) || !w_last_q || (aw_size_q > MAX_SIZE)) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
    end

    // Read response code for the held address.
    always_comb begin
        if (!in_range(ar_addr_q)) begin
            rd_resp_s = RESP_DECERR;
        end else if ((ar_len_q != 8'd0) || (ar_size_q > MAX_SIZE)) begin
            rd_resp_s = RESP_SLVERR;
        end else begin
            rd_resp_s = RESP_OKAY;
        end
    end

    // Storage has no reset so contents persist across resetn; byte lanes follow wstrb.
    always_ff @(posedge clk) begin
        if (wr_commit_s && (wr_resp_s == RESP_OKAY)) begin
            for (int b = 0; b < SB; b++) begin
                if (w_strb_q[b]) begin
                    mem_q[wr_idx_s][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Write channel FSM: independent AW/W holds, latency wait, then B response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= 8'd0;
            aw_size_q <= 3'd0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            w_last_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        aw_held_q <= 1'b1;
                        aw_id_q   <= axi.awid;
                        aw_addr_q <= axi.awaddr;
                        aw_len_q  <= axi.awlen;
                        aw_size_q <= axi.awsize;
                    end
                    if (w_hs_s) begin
                        w_held_q <= 1'b1;
                        w_data_q <= axi.wdata;
                        w_strb_q <= axi.wstrb;
                        w_last_q <= axi.wlast;
                    end
                    awready_q <= ~aw_got_s;
                    wready_q  <= ~w_got_s;
                    if (aw_got_s && w_got_s) begin
                        w_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wr_done_s) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bid_q     <= aw_id_q;
                        bresp_q   <= wr_resp_s;
                    end
                end
                W_RESP: begin
                    // Readies stay low through this edge, giving the mandatory idle cycle.
                    if (axi.bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: capture AR, wait out the latency, then hold R until accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b1;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= 8'd0;
            ar_size_q <= 3'd0;
        end else begin
            rlast_q <= 1'b1;
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        r_state_q <= R_WAIT;
                        arready_q <= 1'b0;
                        ar_id_q   <= axi.arid;
                        ar_addr_q <= axi.araddr;
                        ar_len_q  <= axi.arlen;
                        ar_size_q <= axi.arsize;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rd_done_s) begin
                        r_state_q <= R_RESP;
                        rvalid_q  <= 1'b1;
                        rid_q     <= ar_id_q;
                        rresp_q   <= rd_resp_s;
                        rdata_q   <= (rd_resp_s == RESP_OKAY) ? mem_q[rd_idx_s] : '0;
                    end
                end
                R_RESP: begin
                    if (axi.rready) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;

endmodule

// File: tb/tb_axi_sim_mem_slave.sv
// Directed bench for axi_sim_mem_slave with a transaction-level reference model checked every cycle.
module tb_axi_sim_mem_slave;

    localparam int          WR_LAT    = 1;
    localparam int          RD_LAT    = 2;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_chk;
    int   n_err;
    bit   chk_en;

    axi_sim_mem_slave_if #(.IDW(4), .DW(32), .AW(32)) axi ();

    axi_sim_mem_slave #(
        .IDW(4), .DW(32), .AW(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE),
        .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .axi    (axi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: word-addressed memory plus expected output values.
    logic [31:0] mmem [int];
    logic        e_awready, e_wready, e_bvalid, e_arready, e_rvalid;
    logic [3:0]  e_bid, e_rid;
    logic [1:0]  e_bresp, e_rresp;
    logic [31:0] e_rdata;
    bit          m_aw_have, m_w_have, m_wcool, m_rbusy, m_rcool;
    int          m_b_due, m_r_due;
    logic [3:0]  m_awid, m_arid;
    logic [31:0] m_awaddr, m_araddr, m_wdata;
    logic [7:0]  m_awlen, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [3:0]  m_wstrb;
    logic        m_wlast;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", nm, cyc);
    endtask

    function automatic bit m_in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 32'd4) < MEM_WORDS);
    endfunction

    function automatic int m_key(input logic [31:0] a);
        return int'((a - BASE) / 32'd4);
    endfunction

    task automatic model_reset();
        e_awready = 1'b0; e_wready = 1'b0; e_bvalid = 1'b0; e_bid = 4'd0; e_bresp = 2'd0;
        e_arready = 1'b0; e_rvalid = 1'b0; e_rid = 4'd0; e_rdata = 32'd0; e_rresp = 2'd0;
        m_aw_have = 0; m_w_have = 0; m_wcool = 0; m_rbusy = 0; m_rcool = 0;
    endtask

    task automatic model_step();
        bit aw_hs, w_hs, ar_hs, both_before;
        logic [31:0] w;
        aw_hs = axi.awvalid && e_awready;
        w_hs  = axi.wvalid && e_wready;
        ar_hs = axi.arvalid && e_arready;
        m_wcool = 0;
        m_rcool = 0;
        if (e_bvalid && axi.bready) begin
            e_bvalid = 1'b0; m_aw_have = 0; m_w_have = 0; m_wcool = 1;
        end
        if (e_rvalid && axi.rready) begin
            e_rvalid = 1'b0; m_rbusy = 0; m_rcool = 1;
        end
        both_before = m_aw_have && m_w_have;
        if (aw_hs) begin
            m_aw_have = 1; m_awid = axi.awid; m_awaddr = axi.awaddr;
            m_awlen = axi.awlen; m_awsize = axi.awsize;
        end
        if (w_hs) begin
            m_w_have = 1; m_wdata = axi.wdata; m_wstrb = axi.wstrb; m_wlast = axi.wlast;
        end
        if (!both_before && m_aw_have && m_w_have) m_b_due = cyc + 1 + WR_LAT;
        if (ar_hs) begin
            m_rbusy = 1; m_r_due = cyc + 1 + RD_LAT; m_arid = axi.arid;
            m_araddr = axi.araddr; m_arlen = axi.arlen; m_arsize = axi.arsize;
        end
        // Reads sample before the write lands, so a same-edge collision sees old data.
        if (m_rbusy && !e_rvalid && cyc == m_r_due) begin
            e_rvalid = 1'b1;
            e_rid = m_arid;
            if (!m_in_range(m_araddr)) begin
                e_rresp = 2'b11; e_rdata = 32'd0;
            end else if (m_arlen != 8'd0 || m_arsize > 3'd2) begin
                e_rresp = 2'b10; e_rdata = 32'd0;
            end else begin
                e_rresp = 2'b00;
                e_rdata = mmem.exists(m_key(m_araddr)) ? mmem[m_key(m_araddr)] : 32'hBAD0_BAD0;
            end
        end
        if (m_aw_have && m_w_have && !e_bvalid && cyc == m_b_due) begin
            e_bvalid = 1'b1;
            e_bid = m_awid;
            if (!m_in_range(m_awaddr)) begin
                e_bresp = 2'b11;
            end else if (m_awlen != 8'd0 || !m_wlast || m_awsize > 3'd2) begin
                e_bresp = 2'b10;
            end else begin
                e_bresp = 2'b00;
                w = mmem.exists(m_key(m_awaddr)) ? mmem[m_key(m_awaddr)] : 32'd0;
                for (int b = 0; b < 4; b++) begin
                    if (m_wstrb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                end
                mmem[m_key(m_awaddr)] = w;
            end
        end
        e_awready = !m_aw_have && !m_wcool;
        e_wready  = !m_w_have && !m_wcool;
        e_arready = !m_rbusy && !m_rcool;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!resetn) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge resetn);
            model_reset();
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("awready", axi.awready, e_awready);
                chk("wready",  axi.wready,  e_wready);
                chk("bvalid",  axi.bvalid,  e_bvalid);
                chk("bid",     axi.bid,     e_bid);
                chk("bresp",   axi.bresp,   e_bresp);
                chk("arready", axi.arready, e_arready);
                chk("rvalid",  axi.rvalid,  e_rvalid);
                chk("rid",     axi.rid,     e_rid);
                chk("rdata",   axi.rdata,   e_rdata);
                chk("rresp",   axi.rresp,   e_rresp);
                chk("rlast",   axi.rlast,   1'b1);
            end
        end
    end

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [7:0] len, input logic [2:0] size,
                            input logic last, input int wgap,
                            output int t_aw, output int t_b, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
        if (!axi.awready) timeout("aw_handshake");
        @(posedge clk); #1;
        t_aw = cyc;
        axi.awvalid = 1'b0;
        if (wgap > 0) begin
            repeat (wgap) @(posedge clk);
            #1;
        end
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.wready && n < 50);
        if (!axi.wready) timeout("w_handshake");
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.bvalid && n < 50);
        if (!axi.bvalid) timeout("bvalid_wait");
        t_b = cyc;
        resp = axi.bresp;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input int hold,
                           output int t_ar, output int t_r, output logic [31:0] data,
                           output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
        if (!axi.arready) timeout("ar_handshake");
        @(posedge clk); #1;
        t_ar = cyc;
        axi.arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.rvalid && n < 50);
        if (!axi.rvalid) timeout("rvalid_wait");
        t_r = cyc;
        data = axi.rdata;
        resp = axi.rresp;
        repeat (hold) @(negedge clk);
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    int          t_aw, t_b, t_ar, t_r, t_aw2, t_b2;
    logic [1:0]  resp, resp2;
    logic [31:0] data;

    initial begin
        cyc = 0; n_chk = 0; n_err = 0; chk_en = 0;
        axi.awvalid = 1'b0; axi.awid = 4'd0; axi.awaddr = 32'd0; axi.awsize = 3'd2;
        axi.awprot = 3'd0; axi.awlen = 8'd0; axi.awburst = 2'b01;
        axi.wvalid = 1'b0; axi.wdata = 32'd0; axi.wstrb = 4'h0; axi.wlast = 1'b1;
        axi.bready = 1'b1;
        axi.arvalid = 1'b0; axi.arid = 4'd0; axi.araddr = 32'd0; axi.arsize = 3'd2;
        axi.arprot = 3'd0; axi.arlen = 8'd0; axi.arburst = 2'b01;
        axi.rready = 1'b0;
        model_reset();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_awready", axi.awready, 1'b0);
        chk("reset_rlast", axi.rlast, 1'b1);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("rel_awready_low", axi.awready, 1'b0);
        @(negedge clk);
        chk("rel_awready_high", axi.awready, 1'b1);

        // Basic write then read, with latency pinned relative to the handshakes.
        do_write(4'd3, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, 3'd2, 1'b1, 1, t_aw, t_b, resp);
        chk("t1_b_latency", t_b - t_aw, 4);
        chk("t1_bresp", resp, 2'b00);
        do_read(4'd5, 32'h10, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("t1_r_latency", t_r - t_ar, 3);
        chk("t1_rdata", data, 32'hDEADBEEF);

        // Partial strobe merge.
        do_write(4'd1, 32'h10, 32'h11223344, 4'b0101, 8'd0, 3'd2, 1'b1, 0, t_aw, t_b, resp);
        do_read(4'd2, 32'h10, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("strb_merge", data, 32'hDE22BE44);
        do_read(4'd2, 32'h13, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("unaligned_rd", data, 32'hDE22BE44);

        // Error responses.
        do_read(4'd7, BASE + 32'd4 * MEM_WORDS, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("rd_decerr_resp", resp, 2'b11);
        chk("rd_decerr_data", data, 32'd0);
        do_write(4'd8, 32'h10, 32'hFFFFFFFF, 4'hF, 8'd1, 3'd2, 1'b1, 0, t_aw, t_b, resp);
        chk("wr_len_slverr", resp, 2'b10);
        do_write(4'd9, 32'h10, 32'hFFFFFFFF, 4'hF, 8'd0, 3'd2, 1'b0, 0, t_aw, t_b, resp);
        chk("wr_wlast_slverr", resp, 2'b10);
        do_write(4'd10, 32'h2000, 32'hFFFFFFFF, 4'hF, 8'd0, 3'd2, 1'b1, 0, t_aw, t_b, resp);
        chk("wr_decerr", resp, 2'b11);
        do_read(4'd4, 32'h10, 8'd0, 3'd3, 0, t_ar, t_r, data, resp);
        chk("rd_size_slverr", resp, 2'b10);
        do_read(4'd4, 32'h10, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("err_mem_unchanged", data, 32'hDE22BE44);

        // Back-pressure on R: hold rready low, then release.
        do_read(4'd6, 32'h10, 8'd0, 3'd2, 5, t_ar, t_r, data, resp);
        @(negedge clk);
        chk("bp_arready_low", axi.arready, 1'b0);
        @(negedge clk);
        chk("bp_arready_high", axi.arready, 1'b1);

        // Same-edge write commit and read sample on one word.
        do_write(4'd1, 32'h20, 32'h0, 4'hF, 8'd0, 3'd2, 1'b1, 0, t_aw, t_b, resp);
        fork
            do_write(4'd2, 32'h20, 32'h55, 4'hF, 8'd0, 3'd2, 1'b1, 0, t_aw2, t_b2, resp2);
            do_read(4'd6, 32'h20, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        join
        chk("collide_same_edge", t_b2 - t_r, 0);
        chk("collide_old_data", data, 32'h0);
        do_read(4'd6, 32'h20, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("collide_new_data", data, 32'h55);

        // Reset during the write latency wait must abandon the write.
        do_write(4'd1, 32'h30, 32'hCAFEF00D, 4'hF, 8'd0, 3'd2, 1'b1, 0, t_aw, t_b, resp);
        @(posedge clk); #1;
        axi.awid = 4'd2; axi.awaddr = 32'h30; axi.awlen = 8'd0; axi.awsize = 3'd2; axi.awvalid = 1'b1;
        axi.wdata = 32'h12345678; axi.wstrb = 4'hF; axi.wlast = 1'b1; axi.wvalid = 1'b1;
        @(negedge clk);
        chk("rst_pre_awready", axi.awready, 1'b1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_bvalid", axi.bvalid, 1'b0);
        chk("rst_awready", axi.awready, 1'b0);
        chk("rst_wready", axi.wready, 1'b0);
        chk("rst_arready", axi.arready, 1'b0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rel_awready", axi.awready, 1'b1);
        do_read(4'd3, 32'h30, 8'd0, 3'd2, 0, t_ar, t_r, data, resp);
        chk("rst_word_kept", data, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
